// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM states, resident program
// start/done PC tables and the default watchdog limit.
package prog_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned N_TBL       = 3;
  localparam int unsigned TBL_IW      = $clog2(N_TBL);
  localparam int unsigned DEF_TIMEOUT = 4096;

  localparam int unsigned START_PC [N_TBL] = '{0, 67, 121};
  localparam int unsigned DONE_PC  [N_TBL] = '{66, 120, 170};

  // Out-of-table indices return 0 rather than X.
  function automatic int unsigned start_pc(input int unsigned idx);
    start_pc = 0;
    for (int unsigned i = 0; i < N_TBL; i++)
      if (i == idx) start_pc = START_PC[TBL_IW'(i)];
  endfunction

  function automatic int unsigned done_pc(input int unsigned idx);
    done_pc = 0;
    for (int unsigned i = 0; i < N_TBL; i++)
      if (i == idx) done_pc = DONE_PC[TBL_IW'(i)];
  endfunction

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Width-parametrised up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// Launches resident programs on a core: loads the start PC, watches for the
// done PC or halt, counts run cycles and trips a sticky watchdog on overrun.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter  int unsigned NUM_PROGS = 3,
  parameter  int unsigned PC_W      = 8,
  parameter  int unsigned CYC_W     = 16,
  parameter  int unsigned TIMEOUT   = DEF_TIMEOUT,
  localparam int unsigned PID_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [PID_W-1:0] prog_sel,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt,
  output logic             core_reset,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             busy,
  output logic             done,
  output logic [PID_W-1:0] prog_id,
  output logic [CYC_W-1:0] cycles,
  output logic             timeout_err
);

  state_e           state_q;
  logic             core_reset_q, pc_load_q, busy_q, done_q, timeout_err_q;
  logic             mode_q;
  logic [PID_W-1:0] prog_id_q, next_id;
  logic             bad_sel, launch, finish, expire;

  assign bad_sel = mode && (32'(prog_sel) >= NUM_PROGS);
  assign launch  = (state_q == S_IDLE) && start && !bad_sel;
  assign finish  = halt || (pc == PC_W'(done_pc(32'(prog_id_q))));
  assign expire  = (cycles == CYC_W'(TIMEOUT - 1));
  assign next_id = (prog_id_q == PID_W'(NUM_PROGS - 1)) ? '0 : prog_id_q + 1'b1;

  sat_counter #(.W(CYC_W)) u_cycles (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (launch),
    .en_i   (state_q == S_RUN),
    .cnt_o  (cycles)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      core_reset_q  <= 1'b1;
      pc_load_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      mode_q        <= 1'b0;
      prog_id_q     <= '0;
    end else begin
      pc_load_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          mode_q <= mode;
          if (bad_sel) begin
            state_q       <= S_ERR;
            timeout_err_q <= 1'b1;
          end else begin
            if (mode) prog_id_q <= prog_sel;
            state_q      <= S_LOAD;
            pc_load_q    <= 1'b1;
            busy_q       <= 1'b1;
            core_reset_q <= 1'b0;
          end
        end
        S_LOAD: state_q <= S_RUN;
        // Completion is checked first so it beats a coincident timeout.
        S_RUN: if (finish) begin
          state_q      <= S_DONE;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          core_reset_q <= 1'b1;
        end else if (expire) begin
          state_q       <= S_ERR;
          timeout_err_q <= 1'b1;
          busy_q        <= 1'b0;
          core_reset_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (!mode_q) prog_id_q <= next_id;
        end
        S_ERR: if (start) begin
          state_q       <= S_IDLE;
          timeout_err_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc_load_val = PC_W'(start_pc(32'(prog_id_q)));
  assign core_reset  = core_reset_q;
  assign pc_load     = pc_load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign prog_id     = prog_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized
// launches, checked against a per-launch outcome model.
module tb_prog_sequencer;

  localparam int unsigned TO = 12;
  localparam int unsigned NP = 3;

  int unsigned SPC [NP] = '{0, 67, 121};
  int unsigned DPC [NP] = '{66, 120, 170};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  prog_sel = '0;
  logic [7:0]  pc = '0;
  logic        halt = 1'b0;
  logic        core_reset, pc_load, busy, done, timeout_err;
  logic [7:0]  pc_load_val;
  logic [1:0]  prog_id;
  logic [15:0] cycles;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m_id   = 0;

  prog_sequencer #(
    .NUM_PROGS (NP),
    .PC_W      (8),
    .CYC_W     (16),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .prog_sel    (prog_sel),
    .pc          (pc),
    .halt        (halt),
    .core_reset  (core_reset),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .busy        (busy),
    .done        (done),
    .prog_id     (prog_id),
    .cycles      (cycles),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chkb({tag, "_core_reset"}, core_reset, 1'b1);
    chkb({tag, "_pc_load"}, pc_load, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_done"}, done, 1'b0);
    chk({tag, "_prog_id"}, 32'(prog_id), 0);
    chk({tag, "_cycles"}, 32'(cycles), 0);
    chkb({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  // One launch from IDLE. c = RUN cycle in which completion appears (c > TO
  // means never completes); use_halt picks halt versus reaching the done PC.
  task automatic run_prog(input logic md, input logic [1:0] sel,
                          input int unsigned c, input logic use_halt);
    int unsigned id, exp_id, last;
    logic bad;
    bad = md && (int'(sel) >= NP);
    id  = md ? int'(sel) : m_id;
    start = 1'b1; mode = md; prog_sel = sel; halt = 1'b0; pc = '0;
    step();
    start = 1'b0; mode = 1'($urandom); prog_sel = 2'($urandom);
    if (bad) begin
      chkb("sel_err_flag", timeout_err, 1'b1);
      chkb("sel_err_no_load", pc_load, 1'b0);
      chkb("sel_err_core_reset", core_reset, 1'b1);
      chkb("sel_err_busy", busy, 1'b0);
      chk("sel_err_prog_id", 32'(prog_id), m_id);
      step();
      chkb("err_sticky", timeout_err, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chkb("err_clear", timeout_err, 1'b0);
      chkb("err_clear_no_load", pc_load, 1'b0);
      chkb("err_clear_busy", busy, 1'b0);
      return;
    end
    chkb("load_strobe", pc_load, 1'b1);
    chk("load_val", 32'(pc_load_val), SPC[id]);
    chkb("load_busy", busy, 1'b1);
    chkb("load_core_reset", core_reset, 1'b0);
    chk("load_prog_id", 32'(prog_id), id);
    pc = 8'(SPC[id]);
    last = (c < TO) ? c : TO;
    for (int unsigned k = 1; k <= last; k++) begin
      step();
      chkb("run_no_load", pc_load, 1'b0);
      chk("run_cycles", 32'(cycles), k - 1);
      chkb("run_busy", busy, 1'b1);
      chkb("run_core_reset", core_reset, 1'b0);
      start = 1'($urandom);
      if (k == c) begin
        if (use_halt) halt = 1'b1;
        else          pc = 8'(DPC[id]);
      end else begin
        pc = 8'(SPC[id] + k);
      end
    end
    step();
    start = 1'b0; halt = 1'b0;
    if (c <= TO) begin
      exp_id = md ? id : (id + 1) % NP;
      chkb("done_pulse", done, 1'b1);
      chk("done_cycles", 32'(cycles), c);
      chkb("done_no_timeout", timeout_err, 1'b0);
      chkb("done_busy", busy, 1'b0);
      chk("done_prog_id", 32'(prog_id), id);
      step();
      chkb("done_one_cycle", done, 1'b0);
      chk("next_prog_id", 32'(prog_id), exp_id);
      chk("idle_cycles_frozen", 32'(cycles), c);
      chkb("idle_core_reset", core_reset, 1'b1);
      chkb("idle_busy", busy, 1'b0);
      m_id = exp_id;
    end else begin
      chkb("timeout_flag", timeout_err, 1'b1);
      chkb("timeout_no_done", done, 1'b0);
      chk("timeout_cycles", 32'(cycles), TO);
      chkb("timeout_core_reset", core_reset, 1'b1);
      chkb("timeout_busy", busy, 1'b0);
      step();
      chk("err_cycles_frozen", 32'(cycles), TO);
      chkb("err_sticky", timeout_err, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chkb("err_clear", timeout_err, 1'b0);
      chkb("err_clear_no_load", pc_load, 1'b0);
      chk("err_prog_id", 32'(prog_id), id);
      m_id = id;
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #2 chk_reset_vals("por");
    #5 reset = 1'b1;
    step();
    chk_reset_vals("post_release");

    // Round-robin through all three programs by reaching each done PC.
    run_prog(1'b0, 2'd0, 3, 1'b0);
    run_prog(1'b0, 2'd0, 5, 1'b0);
    run_prog(1'b0, 2'd0, 2, 1'b0);
    chk("rr_wrap", 32'(prog_id), 0);

    // Explicit select of program 2, halted after 10 RUN cycles.
    run_prog(1'b1, 2'd2, 10, 1'b1);
    // Watchdog expiry, then done PC landing exactly on the timeout cycle.
    run_prog(1'b0, 2'd0, TO + 5, 1'b0);
    run_prog(1'b0, 2'd0, TO, 1'b0);
    // Out-of-range explicit select.
    run_prog(1'b1, 2'd3, 4, 1'b0);

    // Reset mid-RUN at cycles=5.
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    pc = 8'(SPC[m_id]);
    repeat (6) step();
    chk("pre_abort_cycles", 32'(cycles), 5);
    #2 reset = 1'b0;
    #1 chk_reset_vals("abort_async");
    #3 reset = 1'b1;
    m_id = 0;
    step();
    chk_reset_vals("abort_after");
    step();
    chkb("abort_no_done", done, 1'b0);

    for (int unsigned i = 0; i < 40; i++) begin
      run_prog(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom_range(1, TO + 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 3: number of resident programs.
REQ-002 Parameter PC_W, default 8: program counter width.
REQ-003 Parameter CYC_W, default 16: cycle counter width.
REQ-004 Parameter TIMEOUT, default 4096: run-cycle limit before error; legal range 1 to 2**CYC_W-1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; low = all state to reset values.
REQ-007 start  in  1  level-sampled request to launch a program.
REQ-008 mode  in  1  0 = auto-advance (round-robin), 1 = explicit select.
REQ-009 prog_sel  in  $clog2(NUM_PROGS)  program index, used when mode=1.
REQ-010 pc  in  PC_W  current core PC.
REQ-011 halt  in  1  core Halt decode.
REQ-012 core_reset  out  1  active-high hold of core PC and overflow flag.
REQ-013 pc_load  out  1  one-cycle absolute PC load strobe.
REQ-014 pc_load_val  out  PC_W  start PC of active program.
REQ-015 busy  out  1  high in LOAD and RUN.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 prog_id  out  $clog2(NUM_PROGS)  index of current/next program.
REQ-018 cycles  out  CYC_W  RUN cycles of current/last program.
REQ-019 timeout_err  out  1  sticky watchdog flag.

Function
REQ-020 FSM states IDLE, LOAD, RUN, DONE, ERR; exactly one active.
REQ-021 IDLE: core_reset=1, busy=0; start=1 -> LOAD, cycles cleared to 0.
REQ-022 IDLE with mode=1: prog_id <= prog_sel at the start edge; prog_sel >= NUM_PROGS -> ERR instead of LOAD, timeout_err=1.
REQ-023 LOAD: lasts exactly 1 cycle; pc_load=1, pc_load_val=START_PC[prog_id], core_reset=0; -> RUN.
REQ-024 RUN: core_reset=0; cycles increments by 1 per cycle, saturating at 2**CYC_W-1.
REQ-025 RUN exit: pc==DONE_PC[prog_id] or halt=1 -> DONE, on the same edge.
REQ-026 RUN timeout: cycles==TIMEOUT-1 with no completion condition -> ERR, timeout_err=1.
REQ-027 Simultaneous completion and timeout in one cycle: DONE wins, timeout_err stays 0.
REQ-028 DONE: done=1 for exactly 1 cycle, cycles frozen; -> IDLE.
REQ-029 DONE with mode=0: prog_id advances by 1, wraps NUM_PROGS-1 -> 0; mode=1: prog_id unchanged.
REQ-030 ERR: core_reset=1, busy=0, cycles frozen; start=1 -> IDLE and clears timeout_err; no program launched by that start.
REQ-031 start ignored in LOAD, RUN, DONE.
REQ-032 Latency start -> pc_load: 1 cycle; completion condition -> done: 1 cycle.
REQ-033 pc_load_val driven combinationally from prog_id; don't-care outside LOAD.
REQ-034 mode, prog_sel sampled only at the IDLE->LOAD edge.

Reset
REQ-035 reset low: state=IDLE, core_reset=1, pc_load=0, busy=0, done=0, prog_id=0, cycles=0, timeout_err=0.
REQ-036 reset asserted mid-RUN aborts immediately; no done pulse, no prog_id advance.
REQ-037 Deassertion takes effect on first rising clk edge after reset goes high.

Structure
REQ-038 Package definitions holds: state enum, START_PC and DONE_PC tables (defaults {0,67,121} and {66,120,170}), TIMEOUT default.
REQ-039 One sub-module sat_counter (width-parametrised, clear/enable/saturate) for cycles.
REQ-040 All outputs registered except pc_load_val.

Verification
REQ-041 mode=0, three start pulses; pc reaches 66, 120, 170 -> done pulses with prog_id 0,1,2, then prog_id=0.
REQ-042 mode=1, prog_sel=2 -> pc_load_val=121 in LOAD; halt after 10 RUN cycles -> done, cycles=10, prog_id stays 2.
REQ-043 TIMEOUT=8, no completion -> ERR after 8 RUN cycles, timeout_err=1, core_reset=1; start -> IDLE, flag 0.
REQ-044 pc==DONE_PC on the timeout cycle -> done=1, timeout_err=0.
REQ-045 reset low during RUN at cycles=5 -> all outputs at reset values asynchronously, no done.
REQ-046 mode=1, prog_sel=3 (NUM_PROGS=3) -> ERR, timeout_err=1, no pc_load.
